// File: rtl/prbs_checker_pkg.sv
// rtl/prbs_checker_pkg.sv - PRBS7 constants, checker state type and shared lock/window defaults.
package prbs_package;

    localparam int PRBS7_ORDER     = 7;
    localparam int TAP_A           = 6;
    localparam int TAP_B           = 5;

    localparam int DEF_LOCK_COUNT  = 32;
    localparam int DEF_WINDOW      = 64;
    localparam int DEF_UNLOCK_ERRS = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } PRBS_CHK_STATE;

    // x^7+x^6+1 with the newest bit in sr[0]
    function automatic logic prbs7_pred(input logic [PRBS7_ORDER-1:0] sr);
        return sr[TAP_A] ^ sr[TAP_B];
    endfunction

endpackage

// File: rtl/prbs_checker_window_monitor.sv
// rtl/prbs_checker_window_monitor.sv - per-window error counter raising unlock_req on an error burst.
module prbs_window_monitor
    import prbs_package::*;
#(
    parameter int WINDOW      = DEF_WINDOW,
    parameter int UNLOCK_ERRS = DEF_UNLOCK_ERRS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cke,
    input  logic enable,
    input  logic err_bit,
    output logic unlock_req
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int ERR_W = $clog2(UNLOCK_ERRS + 1);

    logic [WIN_W-1:0] win_cnt;
    logic [ERR_W-1:0] win_err;
    logic [ERR_W-1:0] win_err_base;
    logic [ERR_W-1:0] win_err_next;
    logic             wrap;

    assign wrap         = (win_cnt == WIN_W'(WINDOW - 1));
    // the bit consumed on the wrap edge opens the new window
    assign win_err_base = wrap ? '0 : win_err;
    assign win_err_next = win_err_base + ERR_W'(err_bit);
    assign unlock_req   = enable && cke && err_bit && (win_err_next >= ERR_W'(UNLOCK_ERRS));

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (cke) begin
            win_cnt <= wrap ? '0 : win_cnt + WIN_W'(1);
            win_err <= win_err_next;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS7 RX checker: self-sync, lock FSM, BER counters; option PRBS_CHECKER_FIRST_ERR_EN.
module prbs_checker
    import prbs_package::*;
#(
    parameter int PRBS_N        = PRBS7_ORDER,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int WINDOW        = DEF_WINDOW,
    parameter int UNLOCK_ERRS   = DEF_UNLOCK_ERRS,
    parameter int BIT_CNT_WIDTH = 40,
    parameter int ERR_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cke,
    input  logic                     data_in,
    input  logic                     clr_cnt,
    output logic                     locked,
    output logic                     err,
    output logic [BIT_CNT_WIDTH-1:0] bit_cnt,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
`ifdef PRBS_CHECKER_FIRST_ERR_EN
    ,
    output logic [BIT_CNT_WIDTH-1:0] first_err_bit,
    output logic                     first_err_valid
`endif
);

    localparam int FILL_W  = $clog2(PRBS_N);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    if (PRBS_N != PRBS7_ORDER) begin : g_bad_order
        $error("prbs_checker: only PRBS_N=7 is supported");
    end
    if (LOCK_COUNT < 1 || WINDOW < 2 || UNLOCK_ERRS < 1) begin : g_bad_cfg
        $error("prbs_checker: LOCK_COUNT>=1, WINDOW>=2, UNLOCK_ERRS>=1 required");
    end

    PRBS_CHK_STATE      state_q, state_d;
    logic [PRBS_N-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               pred;
    logic               in_locked;
    logic               err_bit;
    logic               unlock_req;
    logic               err_d;
    logic               bit_inc;
    logic               err_inc;

    assign pred      = prbs7_pred(sr_q);
    assign in_locked = (state_q == LOCKED);
    assign err_bit   = in_locked && (data_in != pred);
    assign locked    = in_locked;

    prbs_window_monitor #(
        .WINDOW      (WINDOW),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) u_window_monitor (
        .clk        (clk),
        .rst_n      (rst_n),
        .cke        (cke),
        .enable     (in_locked),
        .err_bit    (err_bit),
        .unlock_req (unlock_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sr_q    <= '0;
            fill_q  <= '0;
            match_q <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        err_d   = 1'b0;
        bit_inc = 1'b0;
        err_inc = 1'b0;
        if (cke) begin
            case (state_q)
                HUNT: begin
                    sr_d = {sr_q[PRBS_N-2:0], data_in};
                    if (fill_q == FILL_W'(PRBS_N - 1)) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = VERIFY;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[PRBS_N-2:0], data_in};
                    // an all-zero register would predict zeros forever, so never trust it
                    if ((data_in == pred) && (sr_q != '0)) begin
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            match_d = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        fill_d  = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    sr_d    = {sr_q[PRBS_N-2:0], pred};
                    bit_inc = 1'b1;
                    err_d   = err_bit;
                    err_inc = err_bit;
                    if (unlock_req) begin
                        fill_d  = '0;
                        state_d = HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            err_cnt <= '0;
        end else if (cke && clr_cnt) begin
            bit_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (bit_inc && (bit_cnt != '1)) begin
                bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

`ifdef PRBS_CHECKER_FIRST_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_err_bit   <= '0;
            first_err_valid <= 1'b0;
        end else if (cke && clr_cnt) begin
            first_err_bit   <= '0;
            first_err_valid <= 1'b0;
        end else if (err_inc && !first_err_valid) begin
            first_err_bit   <= bit_cnt;
            first_err_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - randomized self-checking bench for prbs_checker against a behavioural model.
module tb_prbs_checker;

    localparam int N   = 7;
    localparam int LC  = 32;
    localparam int WIN = 64;
    localparam int UE  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cke = 1'b0;
    logic        data_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err;
    logic [39:0] bit_cnt;
    logic [31:0] err_cnt;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
    logic [39:0] first_err_bit;
    logic        first_err_valid;
`endif

    prbs_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cke     (cke),
        .data_in (data_in),
        .clr_cnt (clr_cnt),
        .locked  (locked),
        .err     (err),
        .bit_cnt (bit_cnt),
        .err_cnt (err_cnt)
`ifdef PRBS_CHECKER_FIRST_ERR_EN
        ,
        .first_err_bit   (first_err_bit),
        .first_err_valid (first_err_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // reference PRBS7 source: s[n] = s[n-7] ^ s[n-6]
    bit g_hist[$];

    function automatic void gen_seed();
        g_hist = {};
        for (int i = 0; i < N; i++) g_hist.push_back(1'b1);
    endfunction

    function automatic bit gen_bit();
        bit nb;
        nb = g_hist[0] ^ g_hist[1];
        g_hist.push_back(nb);
        void'(g_hist.pop_front());
        return nb;
    endfunction

    // behavioural model: mode 0=hunt 1=verify 2=locked; m_seq holds the last N bits the checker believes
    int          m_state, m_fill, m_match, m_win, m_werr;
    bit          m_seq[$];
    logic [39:0] m_bits;
    logic [31:0] m_errs;
    bit          m_err;
    logic [39:0] m_fe_bit;
    bit          m_fe_valid;

    function automatic void model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_seq = {};
        for (int i = 0; i < N; i++) m_seq.push_back(1'b0);
        m_bits = '0; m_errs = '0; m_err = 1'b0;
        m_fe_bit = '0; m_fe_valid = 1'b0;
    endfunction

    function automatic void model_step(input bit c, input bit d, input bit clr);
        bit pred, e, zero;
        m_err = 1'b0;
        if (!c) return;
        pred = m_seq[0] ^ m_seq[1];
        case (m_state)
            0: begin
                m_seq.push_back(d);
                m_fill++;
                if (m_fill == N) begin m_state = 1; m_match = 0; m_fill = 0; end
            end
            1: begin
                zero = 1'b1;
                foreach (m_seq[i]) if (m_seq[i]) zero = 1'b0;
                m_seq.push_back(d);
                if (d == pred && !zero) begin
                    m_match++;
                    if (m_match == LC) begin m_state = 2; m_win = 0; m_werr = 0; end
                end else begin
                    m_state = 0; m_fill = 0;
                end
            end
            default: begin
                m_seq.push_back(pred);
                e = (d != pred);
                if (e && !m_fe_valid) begin m_fe_bit = m_bits; m_fe_valid = 1'b1; end
                if (m_bits != '1) m_bits++;
                if (e) begin
                    m_err = 1'b1;
                    if (m_errs != '1) m_errs++;
                end
                if (m_win == WIN - 1) begin m_win = 0; m_werr = int'(e); end
                else begin m_win++; m_werr += int'(e); end
                if (m_werr >= UE) begin m_state = 0; m_fill = 0; end
            end
        endcase
        void'(m_seq.pop_front());
        if (clr) begin m_bits = '0; m_errs = '0; m_fe_valid = 1'b0; m_fe_bit = '0; end
    endfunction

    task automatic apply(input bit c, input bit d, input bit clr);
        cke = c; data_in = d; clr_cnt = clr;
        @(posedge clk);
        model_step(c, d, clr);
        #1;
    endtask

    task automatic do_reset(input bit c);
        rst_n = 1'b0; cke = c; data_in = 1'($urandom); clr_cnt = 1'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_vec++;
        if (locked !== 1'b0 || err !== 1'b0 || bit_cnt !== 40'd0 || err_cnt !== 32'd0) begin
            n_mis++;
            $display("FAIL reset: locked=%b err=%b bit_cnt=%0d err_cnt=%0d, want 0 0 0 0", locked, err, bit_cnt, err_cnt);
        end
    endtask

    task automatic test_clean_lock();
        do_reset(1'b1);
        gen_seed();
        for (int i = 1; i <= N + LC; i++) begin
            apply(1'b1, gen_bit(), 1'b0);
            n_vec++;
            if (locked !== (i == N + LC) || err !== 1'b0) begin
                n_mis++;
                $display("FAIL lock_time bit=%0d: locked=%b err=%b, want %b 0", i, locked, err, i == N + LC);
            end
        end
        for (int i = 1; i <= 1000; i++) begin
            apply(1'b1, gen_bit(), 1'b0);
            n_vec++;
            if (locked !== 1'b1 || err !== 1'b0 || bit_cnt !== m_bits || err_cnt !== m_errs) begin
                n_mis++;
                $display("FAIL clean_run bit=%0d: locked=%b err=%b bit_cnt=%0d err_cnt=%0d, want 1 0 %0d %0d",
                         i, locked, err, bit_cnt, err_cnt, m_bits, m_errs);
            end
        end
        n_vec++;
        if (bit_cnt !== 40'd1000 || err_cnt !== 32'd0) begin
            n_mis++;
            $display("FAIL clean_totals: bit_cnt=%0d err_cnt=%0d, want 1000 0", bit_cnt, err_cnt);
        end
    endtask

    task automatic test_sparse_errors();
        int off, flips;
        logic [31:0] base;
        bit f;
        base = err_cnt;
        off = $urandom_range(0, 19);
        flips = 0;
        for (int i = 0; i < 200; i++) begin
            f = ((i % 20) == off);
            flips += int'(f);
            apply(1'b1, gen_bit() ^ f, 1'b0);
            n_vec++;
            if (err !== f || locked !== 1'b1 || err_cnt !== base + 32'(flips)) begin
                n_mis++;
                $display("FAIL sparse_err i=%0d: err=%b locked=%b err_cnt=%0d, want %b 1 %0d",
                         i, err, locked, err_cnt, f, base + 32'(flips));
            end
        end
    endtask

    task automatic test_burst_unlock();
        int tgt;
        tgt = $urandom_range(0, 40);
        for (int i = 0; i < WIN && m_win != tgt; i++) apply(1'b1, gen_bit(), 1'b0);
        apply(1'b1, gen_bit(), 1'b1);
        for (int k = 1; k <= UE; k++) begin
            apply(1'b1, ~gen_bit(), 1'b0);
            n_vec++;
            if (err !== 1'b1 || err_cnt !== 32'(k) || locked !== (k < UE)) begin
                n_mis++;
                $display("FAIL burst k=%0d: err=%b err_cnt=%0d locked=%b, want 1 %0d %b", k, err, err_cnt, locked, k, k < UE);
            end
        end
        for (int i = 1; i <= N + LC; i++) begin
            apply(1'b1, gen_bit(), 1'b0);
            n_vec++;
            if (locked !== (i == N + LC) || err_cnt !== 32'd8 || bit_cnt !== 40'd8 || err !== 1'b0) begin
                n_mis++;
                $display("FAIL relock i=%0d: locked=%b err_cnt=%0d bit_cnt=%0d err=%b, want %b 8 8 0",
                         i, locked, err_cnt, bit_cnt, err, i == N + LC);
            end
        end
        for (int i = 1; i <= 20; i++) begin
            apply(1'b1, gen_bit(), 1'b0);
            n_vec++;
            if (bit_cnt !== 40'(8 + i) || err_cnt !== 32'd8) begin
                n_mis++;
                $display("FAIL resume i=%0d: bit_cnt=%0d err_cnt=%0d, want %0d 8", i, bit_cnt, err_cnt, 8 + i);
            end
        end
    endtask

    task automatic test_cke_toggle();
        bit ce;
        int high_cnt;
        do_reset(1'b0);
        gen_seed();
        for (int c = 1; c <= 2 * (N + LC); c++) begin
            ce = (c % 2) == 1;
            apply(ce, ce ? gen_bit() : 1'($urandom), 1'b0);
            n_vec++;
            if (locked !== (c >= 2 * (N + LC) - 1) || err !== 1'b0) begin
                n_mis++;
                $display("FAIL cke_lock clk=%0d: locked=%b err=%b, want %b 0", c, locked, err, c >= 2 * (N + LC) - 1);
            end
        end
        high_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            ce = 1'($urandom);
            high_cnt += int'(ce);
            apply(ce, ce ? gen_bit() : 1'($urandom), 1'b0);
            n_vec++;
            if (bit_cnt !== 40'(high_cnt) || err !== 1'b0 || locked !== 1'b1) begin
                n_mis++;
                $display("FAIL cke_count c=%0d: bit_cnt=%0d err=%b locked=%b, want %0d 0 1", c, bit_cnt, err, locked, high_cnt);
            end
        end
    endtask

    task automatic test_clr_on_error();
        for (int i = 0; i < 5; i++) apply(1'b1, gen_bit(), 1'b0);
        apply(1'b1, ~gen_bit(), 1'b1);
        n_vec++;
        if (err !== 1'b1 || err_cnt !== 32'd0 || bit_cnt !== 40'd0 || locked !== 1'b1) begin
            n_mis++;
            $display("FAIL clr_err: err=%b err_cnt=%0d bit_cnt=%0d locked=%b, want 1 0 0 1", err, err_cnt, bit_cnt, locked);
        end
        apply(1'b1, gen_bit(), 1'b0);
        n_vec++;
        if (err !== 1'b0 || bit_cnt !== 40'd1 || err_cnt !== 32'd0) begin
            n_mis++;
            $display("FAIL clr_after: err=%b bit_cnt=%0d err_cnt=%0d, want 0 1 0", err, bit_cnt, err_cnt);
        end
    endtask

    task automatic test_all_zero();
        do_reset(1'b1);
        for (int i = 0; i < 600; i++) begin
            apply(1'b1, 1'b0, 1'b0);
            n_vec++;
            if (locked !== 1'b0 || err !== 1'b0 || bit_cnt !== 40'd0 || err_cnt !== 32'd0) begin
                n_mis++;
                $display("FAIL all_zero i=%0d: locked=%b err=%b bit_cnt=%0d err_cnt=%0d, want 0 0 0 0",
                         i, locked, err, bit_cnt, err_cnt);
            end
        end
    endtask

    task automatic test_first_err();
`ifdef PRBS_CHECKER_FIRST_ERR_EN
        do_reset(1'b1);
        gen_seed();
        for (int i = 0; i < N + LC; i++) apply(1'b1, gen_bit(), 1'b0);
        apply(1'b1, gen_bit(), 1'b1);
        for (int i = 0; i < 600; i++) begin
            apply(1'b1, gen_bit() ^ (i == 500 || i == 550), 1'b0);
            n_vec++;
            if (first_err_valid !== (i >= 500) || first_err_bit !== ((i >= 500) ? 40'd500 : 40'd0)) begin
                n_mis++;
                $display("FAIL first_err i=%0d: valid=%b bit=%0d, want %b %0d", i, first_err_valid, first_err_bit,
                         i >= 500, (i >= 500) ? 500 : 0);
            end
        end
`endif
    endtask

    task automatic test_random();
        bit ce, f, clr;
        int burst;
        do_reset(1'b1);
        gen_seed();
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            ce = ($urandom_range(0, 3) != 0);
            if (burst == 0 && $urandom_range(0, 399) == 0) burst = $urandom_range(4, 12);
            f = (burst > 0) || ($urandom_range(0, 99) < 3);
            if (ce && burst > 0) burst--;
            clr = ($urandom_range(0, 199) == 0);
            apply(ce, ce ? (gen_bit() ^ f) : 1'($urandom), clr);
            n_vec++;
            if (locked !== (m_state == 2) || err !== m_err || bit_cnt !== m_bits || err_cnt !== m_errs) begin
                n_mis++;
                $display("FAIL random c=%0d: locked=%b err=%b bit_cnt=%0d err_cnt=%0d, want %b %b %0d %0d",
                         c, locked, err, bit_cnt, err_cnt, m_state == 2, m_err, m_bits, m_errs);
            end
`ifdef PRBS_CHECKER_FIRST_ERR_EN
            n_vec++;
            if (first_err_valid !== m_fe_valid || first_err_bit !== m_fe_bit) begin
                n_mis++;
                $display("FAIL random_fe c=%0d: valid=%b bit=%0d, want %b %0d", c, first_err_valid, first_err_bit,
                         m_fe_valid, m_fe_bit);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        gen_seed();
        for (int i = 0; i < N + LC + 10; i++) apply(1'b1, gen_bit() ^ (i == N + LC + 3), 1'b0);
        do_reset(1'b0);
        n_vec++;
        if (locked !== 1'b0 || err !== 1'b0 || bit_cnt !== 40'd0 || err_cnt !== 32'd0) begin
            n_mis++;
            $display("FAIL reset_mid: locked=%b err=%b bit_cnt=%0d err_cnt=%0d, want 0 0 0 0", locked, err, bit_cnt, err_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_sparse_errors();
        test_burst_unlock();
        test_cke_toggle();
        test_clr_on_error();
        test_all_zero();
        test_first_err();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
